i2c_master: RTL
===============

// Module: i2c_master
// PURPOSE
//   Single-byte I2C bus master that drives the bus our i2c_slave sits on.
//   A host issues one command: 7-bit address, R/W, and write byte.
//   The block generates START, address+R/W, one data byte, ACK/NACK and STOP on open-drain SCL/SDA.
//   It returns the read byte or an ACK error.
//   All logic runs on the single system clock; SCL is derived by a divider.
// PARAMETERS
//   QUARTER   5   clk cycles per SCL quarter-period (SCL period = 4*QUARTER clk; 5 -> 5 MHz SCL at 100 MHz clk)
//   CNT_W     8   width of quarter-period counter; QUARTER must be < 2**CNT_W
// PORTS
//   clk         in    1  system clock, rising edge
//   reset       in    1  asynchronous, active-high reset
//   cmd_valid   in    1  host command request
//   cmd_ready   out   1  high in IDLE; command accepted when cmd_valid & cmd_ready
//   addr        in    7  slave address, sampled on accept
//   rw          in    1  0 = write, 1 = read, sampled on accept
//   wr_data     in    8  byte to write, sampled on accept
//   rd_data     out   8  byte read from slave, valid with rd_valid
//   rd_valid    out   1  one-clk pulse when a read completes without address NACK
//   done        out   1  one-clk pulse when STOP completes (any outcome)
//   ack_error   out   1  set on any slave NACK; cleared on next command accept
//   busy        out   1  ~cmd_ready
//   scl         inout 1  open drain: driven 0 or released to 1'bz
//   sda         inout 1  open drain: driven 0 or released to 1'bz
// BEHAVIOUR
//   - Reset (async): state IDLE, SCL/SDA released, cmd_ready=1, rd_data=0, rd_valid=0, done=0, ack_error=0.
//     Reset mid-transfer releases the bus immediately and issues no STOP.
//   - Bit timing: each bit has 4 quarters Q0..Q3 of QUARTER clks.
//     SCL is low in Q0-Q1 and released in Q2-Q3.
//     SDA changes only at the start of Q0.
//     SDA is sampled on the last clk of Q2.
//   - FSM: IDLE -> START -> ADDR(8 bits: addr[6:0],rw, MSB first) -> ADDR_ACK
//     -> WRITE(8 bits, MSB first) -> WRITE_ACK -> STOP -> IDLE
//     or -> READ(8 bits, MSB first) -> READ_ACK -> STOP -> IDLE.
//   - START: SCL and SDA both released for 2 quarters. SDA is then pulled low with SCL high for 2 quarters.
//     SCL then goes low, entering ADDR Q0.
//   - ADDR_ACK/WRITE_ACK: SDA is released; the sampled bit is 1 for NACK and 0 for ACK.
//     NACK sets ack_error and jumps to STOP, skipping data after an address NACK.
//   - READ: SDA released for all 8 bits; sampled bits shift into rd_data MSB first.
//   - READ_ACK: master drives NACK (SDA released), because transfers are single-byte.
//   - STOP: SDA low with SCL low (Q0-Q1), then SCL released (Q2).
//     SDA is released at the start of Q3 and held one more quarter.
//     Then done pulses; rd_valid pulses too if rw=1 and there was no address NACK.
//   - Bit counter is 3 bits and wraps 7->0 only at a byte end. The quarter counter reloads at QUARTER-1.
//   - cmd_valid asserted while busy is ignored (not queued).
//     A command presented on the clk where done pulses is not accepted until the next cycle.
//   - No arbitration-loss detection; the block assumes it is the only master.
// CONFIGURATION
//   I2C_MASTER_CLK_STRETCH_EN
//     defined:   on entering Q2, the quarter counter holds while the scl pin reads 0.
//                The slave may stretch indefinitely; timing resumes when scl reads 1.
//     undefined: scl readback is ignored; timing is purely counter-based.
// TESTING
//   Use a tri1 pull-up on scl/sda and the existing i2c_slave (7-bit address 7'b1101010) as DUT partner.
//   1 Write: addr=7'h6A rw=0 wr_data=8'hAA
//     -> bus bits 0xD4,ACK,0xAA,ACK
//     -> slave data_out=8'hAA with data_ready; done pulse; ack_error=0
//   2 Read: addr=7'h6A rw=1, slave data_in=8'hCC
//     -> rd_data=8'hCC, rd_valid and done pulse same clk, master NACK seen on 9th bit
//   3 Address NACK: addr=7'h11 rw=0
//     -> ack_error=1, no data byte on bus, STOP follows ADDR_ACK
//     -> ack_error clears on next accepted command
//   4 Timing: QUARTER=5 -> SCL period 20 clk.
//     SDA never toggles while SCL high, except START (falling) and STOP (rising).
//   5 Reset asserted mid-data byte -> scl/sda read 1 within same clk, cmd_ready=1
//     -> a following write completes normally
//   6 With I2C_MASTER_CLK_STRETCH_EN: bench holds scl low 37 clk during ADDR bit 3 Q2
//     -> that bit's high phase starts after release; byte still 0xD4

Source files
------------

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, addr+R/W, one data byte, ACK/NACK, STOP on open-drain SCL/SDA.
// Optional define I2C_MASTER_CLK_STRETCH_EN: honour slave clock stretching at the SCL high phase.
module i2c_master #(
  parameter int QUARTER = 5,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       ack_error,
  output logic       busy,
  inout  wire        scl,
  inout  wire        sda
);
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] QLOAD = CNT_W'(QUARTER - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] qcnt_q;
  logic [1:0]       quar_q;
  logic [2:0]       bit_q;
  logic [7:0]       tx_q, wdata_q, rd_data_q;
  logic             rw_q, samp_q, rd_valid_q, done_q, ack_error_q;
  logic             scl_low, sda_low, accept, stall, q_end, bit_end, sample;

  // Holding ready low on the done clk keeps a same-cycle command from slipping in.
  assign cmd_ready = (state_q == S_IDLE) & ~done_q;
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign stall = (state_q != S_IDLE) && (quar_q == 2'd2) && (qcnt_q == QLOAD) && !scl;
`else
  assign stall = 1'b0;
`endif

  assign q_end   = ~stall & (qcnt_q == '0);
  assign sample  = q_end & (quar_q == 2'd2);
  assign bit_end = q_end & (quar_q == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_d = S_START;
      S_START:     if (bit_end) state_d = S_ADDR;
      S_ADDR:      if (bit_end && bit_q == 3'd7) state_d = S_ADDR_ACK;
      S_ADDR_ACK:  if (bit_end) state_d = samp_q ? S_STOP : (rw_q ? S_READ : S_WRITE);
      S_WRITE:     if (bit_end && bit_q == 3'd7) state_d = S_WRITE_ACK;
      S_WRITE_ACK: if (bit_end) state_d = S_STOP;
      S_READ:      if (bit_end && bit_q == 3'd7) state_d = S_READ_ACK;
      S_READ_ACK:  if (bit_end) state_d = S_STOP;
      S_STOP:      if (bit_end) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // SCL low in Q0-Q1 of every bit; quar_q[1] marks the high half.
  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (state_q)
      S_START: sda_low = quar_q[1];
      S_ADDR, S_WRITE: begin
        scl_low = ~quar_q[1];
        sda_low = ~tx_q[7];
      end
      S_ADDR_ACK, S_WRITE_ACK, S_READ, S_READ_ACK: scl_low = ~quar_q[1];
      S_STOP: begin
        scl_low = ~quar_q[1];
        sda_low = (quar_q != 2'd3);
      end
      default: ;
    endcase
  end

  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qcnt_q      <= QLOAD;
      quar_q      <= 2'd0;
      bit_q       <= 3'd0;
      tx_q        <= 8'd0;
      wdata_q     <= 8'd0;
      rd_data_q   <= 8'd0;
      rw_q        <= 1'b0;
      samp_q      <= 1'b1;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      if (state_q == S_IDLE) begin
        qcnt_q <= QLOAD;
        quar_q <= 2'd0;
        bit_q  <= 3'd0;
      end else if (!stall) begin
        if (qcnt_q == '0) begin
          qcnt_q <= QLOAD;
          quar_q <= quar_q + 2'd1;
        end else begin
          qcnt_q <= qcnt_q - CNT_W'(1);
        end
      end
      if (accept) begin
        tx_q        <= {addr, rw};
        wdata_q     <= wr_data;
        rw_q        <= rw;
        ack_error_q <= 1'b0;
      end
      if (sample) begin
        samp_q <= sda;
        if (state_q == S_READ) rd_data_q <= {rd_data_q[6:0], sda};
        if ((state_q == S_ADDR_ACK || state_q == S_WRITE_ACK) && sda) ack_error_q <= 1'b1;
      end
      if (bit_end) begin
        if (state_q inside {S_ADDR, S_WRITE, S_READ}) bit_q <= bit_q + 3'd1;
        if (state_q == S_ADDR || state_q == S_WRITE) tx_q <= {tx_q[6:0], 1'b0};
        if (state_q == S_ADDR_ACK) tx_q <= wdata_q;
        // Only an address NACK can occur on a read, so ack_error alone gates rd_valid.
        if (state_q == S_STOP) begin
          done_q     <= 1'b1;
          rd_valid_q <= rw_q & ~ack_error_q;
        end
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;
endmodule
